// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the core and the multiply/divide unit.
//   master (core side): drives start, kill, funct3, rs1_data, rs2_data, rd_in;
//                       observes busy, done, result, rd_out.
//   slave  (unit side): the mirror image.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 64
) ();

  logic            start;
  logic            kill;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, kill, funct3, rs1_data, rs2_data, rd_in,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, kill, funct3, rs1_data, rs2_data, rd_in,
    output busy, done, result, rd_out
  );

endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide unit.
//   clk   - rising-edge clock
//   reset - asynchronous, active-high
//   bus   - muldiv_unit_if.slave:
//     start/kill/funct3/rs1_data/rs2_data/rd_in in, busy/done/result/rd_out out.
// Operands are reduced to magnitudes at accept; 64 CALC cycles run either an unsigned
// shift-add multiply or a restoring divide on {hi_q, lo_q}; FIX restores the sign and
// picks the output. Divide-by-zero and signed overflow finish straight from accept.
module muldiv_unit #(
  parameter int unsigned XLEN = 64
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);

  localparam int unsigned CntW    = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpDiv    = 3'd4;
  localparam logic [2:0] OpRem    = 3'd6;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_cap_q, rd_cap_d, rd_out_q, rd_out_d;

  // Accept-time operand decode.
  logic            a_signed, b_signed, a_neg, b_neg;
  logic            is_div, is_rem, div_zero, div_ovf, accept;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  always_comb begin
    a_signed = (bus.funct3 == OpMulh) || (bus.funct3 == OpMulhsu) ||
               (bus.funct3 == OpDiv)  || (bus.funct3 == OpRem);
    b_signed = (bus.funct3 == OpMulh) || (bus.funct3 == OpDiv) || (bus.funct3 == OpRem);
    a_neg    = a_signed && bus.rs1_data[XLEN-1];
    b_neg    = b_signed && bus.rs2_data[XLEN-1];
    a_mag    = a_neg ? -bus.rs1_data : bus.rs1_data;
    b_mag    = b_neg ? -bus.rs2_data : bus.rs2_data;
    is_div   = bus.funct3[2];
    is_rem   = is_div && bus.funct3[1];
    div_zero = is_div && (bus.rs2_data == '0);
    div_ovf  = ((bus.funct3 == OpDiv) || (bus.funct3 == OpRem)) &&
               (bus.rs1_data == {1'b1, {(XLEN - 1){1'b0}}}) && (bus.rs2_data == '1);
    // On overflow the quotient equals the dividend itself (most negative value).
    if (div_zero) begin
      fast_res = is_rem ? bus.rs1_data : '1;
    end else begin
      fast_res = is_rem ? '0 : bus.rs1_data;
    end
  end

  // One iteration of each datapath.
  logic [XLEN:0] mul_sum, div_sh, div_diff;
  logic          div_ge;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_ge   = div_sh >= {1'b0, b_q};
    div_diff = div_sh - {1'b0, b_q};
  end

  // Sign fix-up and output select.
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   div_val, div_fix, fix_res;

  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
    div_val  = op_q[1] ? hi_q : lo_q;
    div_fix  = neg_q ? -div_val : div_val;
    if (op_q[2]) begin
      fix_res = div_fix;
    end else if (op_q == OpMul) begin
      fix_res = prod_fix[XLEN-1:0];
    end else begin
      fix_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    result_d = result_q;
    rd_cap_d = rd_cap_q;
    rd_out_d = rd_out_q;
    accept   = bus.start && !bus.kill && ((state_q == StIdle) || (state_q == StDone));

    if (bus.kill) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          state_d = StIdle;
          if (accept) begin
            op_d     = bus.funct3;
            rd_cap_d = bus.rd_in;
            // Remainder follows the dividend; everything else follows the sign product.
            neg_d    = is_rem ? a_neg : (a_neg ^ b_neg);
            cnt_d    = '0;
            if (div_zero || div_ovf) begin
              result_d = fast_res;
              rd_out_d = bus.rd_in;
              state_d  = StDone;
            end else begin
              // Multiply: lo holds the multiplier, b the multiplicand.
              // Divide: lo holds the dividend (becomes quotient), hi the partial remainder.
              hi_d    = '0;
              lo_d    = is_div ? a_mag : b_mag;
              b_d     = is_div ? b_mag : a_mag;
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          if (op_q[2]) begin
            hi_d = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], div_ge};
          end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_d = StFix;
          end
        end
        StFix: begin
          result_d = fix_res;
          rd_out_d = rd_cap_q;
          state_d  = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
      rd_cap_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
      rd_cap_q <= rd_cap_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign bus.busy   = (state_q == StCalc) || (state_q == StFix);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven vectors plus hand-written corner sequences.
// Expected results are queued when an operation is issued and checked when done pulses.
module tb_muldiv_unit;

  logic clk;
  logic reset;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  rd;
  } exp_t;

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] exp;
    bit          fast;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [63:0] last_res;
  logic [4:0]  last_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_result", bus.result, e.res);
        check("sb_rd", {59'd0, bus.rd_out}, {59'd0, e.rd});
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input logic [63:0] exp, input bit push);
    if (push) sb_q.push_back(exp_t'{res: exp, rd: rd});
    bus.funct3   = f;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_in    = rd;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
  endtask

  // Counts cycles (and busy cycles) until done, bounded.
  task automatic wait_done(input int exp_lat, input string name);
    int lat;
    int bcnt;
    lat  = 0;
    bcnt = 0;
    while (!bus.done && lat < 200) begin
      if (bus.busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.kill     = 1'b0;
    bus.funct3   = '0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.rd_in    = '0;

    vecs.push_back('{"mul_7_m3",     3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5,
                     64'hFFFF_FFFF_FFFF_FFEB, 1'b0});
    vecs.push_back('{"mulhu_ones",   3'd3, '1, '1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
    vecs.push_back('{"mulh_ones",    3'd1, '1, '1, 5'd7, 64'd0, 1'b0});
    vecs.push_back('{"mulhsu_ones",  3'd2, '1, '1, 5'd8, '1, 1'b0});
    vecs.push_back('{"mulhsu_2_2p63", 3'd2, 64'd2, 64'h8000_0000_0000_0000, 5'd9, 64'd1, 1'b0});
    vecs.push_back('{"mulh_2_m2p63", 3'd1, 64'd2, 64'h8000_0000_0000_0000, 5'd10, '1, 1'b0});
    vecs.push_back('{"mul_2p32sq",   3'd0, 64'h1_0000_0000, 64'h1_0000_0000, 5'd11, 64'd0, 1'b0});
    vecs.push_back('{"mulhu_2p32sq", 3'd3, 64'h1_0000_0000, 64'h1_0000_0000, 5'd12, 64'd1, 1'b0});
    vecs.push_back('{"div_m7_2",     3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd13,
                     64'hFFFF_FFFF_FFFF_FFFD, 1'b0});
    vecs.push_back('{"rem_m7_2",     3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd14, '1, 1'b0});
    vecs.push_back('{"div_7_m2",     3'd4, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd15,
                     64'hFFFF_FFFF_FFFF_FFFD, 1'b0});
    vecs.push_back('{"rem_7_m2",     3'd6, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd16, 64'd1, 1'b0});
    vecs.push_back('{"divu_100_7",   3'd5, 64'd100, 64'd7, 5'd17, 64'd14, 1'b0});
    vecs.push_back('{"remu_100_7",   3'd7, 64'd100, 64'd7, 5'd18, 64'd2, 1'b0});
    vecs.push_back('{"div_min_1",    3'd4, 64'h8000_0000_0000_0000, 64'd1, 5'd19,
                     64'h8000_0000_0000_0000, 1'b0});
    vecs.push_back('{"divu_by0",     3'd5, 64'h1234, 64'd0, 5'd20, '1, 1'b1});
    vecs.push_back('{"remu_by0",     3'd7, 64'h1234, 64'd0, 5'd21, 64'h1234, 1'b1});
    vecs.push_back('{"div_m5_by0",   3'd4, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd22, '1, 1'b1});
    vecs.push_back('{"rem_m5_by0",   3'd6, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd23,
                     64'hFFFF_FFFF_FFFF_FFFB, 1'b1});
    vecs.push_back('{"div_ovf",      3'd4, 64'h8000_0000_0000_0000, '1, 5'd24,
                     64'h8000_0000_0000_0000, 1'b1});
    vecs.push_back('{"rem_ovf",      3'd6, 64'h8000_0000_0000_0000, '1, 5'd25, 64'd0, 1'b1});

    // Reset state, checked while reset is still held.
    #2;
    check("reset_busy",   {63'd0, bus.busy}, 64'd0);
    check("reset_done",   {63'd0, bus.done}, 64'd0);
    check("reset_result", bus.result, 64'd0);
    check("reset_rd",     {59'd0, bus.rd_out}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, 1'b1);
      wait_done(vecs[i].fast ? 0 : 65, vecs[i].name);
      @(posedge clk);
      #1;
      check({vecs[i].name, "_after"}, {62'd0, bus.busy, bus.done}, 64'd0);
      last_res = vecs[i].exp;
      last_rd  = vecs[i].rd;
    end

    // start during CALC is ignored; the original operation completes on schedule.
    issue(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    issue(3'd3, 64'd3, 64'd3, 5'd9, 64'd9, 1'b0);
    wait_done(55, "ignore_start");
    repeat (70) @(posedge clk);
    #1;
    check("ignore_start_idle", {62'd0, bus.busy, bus.done}, 64'd0);
    last_res = 64'hFFFF_FFFF_FFFF_FFEB;
    last_rd  = 5'd5;

    // Back-to-back: start during DONE; old result held until the new op finishes.
    issue(3'd5, 64'd100, 64'd7, 5'd3, 64'd14, 1'b1);
    wait_done(65, "b2b_first");
    issue(3'd3, '1, '1, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    check("b2b_busy", {63'd0, bus.busy}, 64'd1);
    check("b2b_held_result", bus.result, 64'd14);
    check("b2b_held_rd", {59'd0, bus.rd_out}, 64'd3);
    wait_done(65, "b2b_second");
    @(posedge clk);
    #1;
    last_res = 64'hFFFF_FFFF_FFFF_FFFE;
    last_rd  = 5'd4;

    // kill at cycle 30 of CALC.
    issue(3'd4, 64'd1000, 64'd3, 5'd30, 64'd0, 1'b0);
    repeat (29) @(posedge clk);
    #1;
    check("kill_busy_before", {63'd0, bus.busy}, 64'd1);
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    check("kill_busy", {63'd0, bus.busy}, 64'd0);
    repeat (80) @(posedge clk);
    #1;
    check("kill_result", bus.result, last_res);
    check("kill_rd", {59'd0, bus.rd_out}, {59'd0, last_rd});
    check("kill_idle", {62'd0, bus.busy, bus.done}, 64'd0);

    // kill wins over start in IDLE.
    bus.kill = 1'b1;
    issue(3'd5, 64'h1234, 64'd0, 5'd2, 64'd0, 1'b0);
    bus.kill = 1'b0;
    check("kill_over_start", {62'd0, bus.busy, bus.done}, 64'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-CALC clears outputs before the next edge.
    issue(3'd0, 64'd5, 64'd6, 5'd27, 64'd0, 1'b0);
    repeat (20) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("areset_busy",   {63'd0, bus.busy}, 64'd0);
    check("areset_done",   {63'd0, bus.done}, 64'd0);
    check("areset_result", bus.result, 64'd0);
    check("areset_rd",     {59'd0, bus.rd_out}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    check("areset_idle", {62'd0, bus.busy, bus.done}, 64'd0);

    // Recovery after reset.
    issue(3'd7, 64'd100, 64'd7, 5'd31, 64'd2, 1'b1);
    wait_done(65, "post_reset");
    repeat (3) @(posedge clk);
    #1;

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV64M multiply/divide execution unit. It sits between register-file reads and register-file writeback in the sequential core.
- Takes rs1/rs2 operand values and funct3, computes over multiple cycles, and returns a 64-bit result plus destination register index for the writeback path.
- Start/busy/done handshake; the core stalls while busy.

Parameters:
XLEN, 64, operand/result width; only 64 is supported.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
start  input  1  request a new operation; sampled on rising edge
kill  input  1  synchronous abort of the in-flight operation
funct3  input  3  RV64M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_data  input  64  operand A (multiplicand / dividend)
rs2_data  input  64  operand B (multiplier / divisor)
rd_in  input  5  destination register tag, carried through
busy  output  1  operation in progress; new start not accepted
done  output  1  one-cycle pulse: result/rd_out valid
result  output  64  computed value; held until next accepted start
rd_out  output  5  rd_in captured at accept; held like result

Behaviour:
- Reset is asynchronous, active-high; clock is clk. On reset: state=IDLE, busy=0, done=0, result=0, rd_out=0, all internal registers 0. Reset mid-operation abandons the operation with no done.
- States: IDLE, CALC, FIX, DONE.
- busy=1 in CALC and FIX only. done=1 in DONE only.
- Accept: start=1 and kill=0 at an edge while in IDLE or DONE. Accept captures funct3 and rd_in, and captures operand magnitudes plus sign flags.
- Signedness: MULH, DIV and REM treat both operands as signed. MULHSU treats rs1 as signed and rs2 as unsigned. MUL, MULHU, DIVU and REMU are unsigned.
- start while busy is ignored; no queuing.
- Normal path:
  - Accept edge -> CALC, counter=0.
  - 64 CALC edges, one iteration each: shift-add for multiply into a 128-bit accumulator; restoring shift-subtract for divide.
  - Counter reaches 63 -> FIX.
  - FIX edge applies sign correction (two's-complement negate of the magnitude result when required) and selects the output, then -> DONE.
  - done rises in the cycle after edge 65 counted from the accept edge; accept edge is edge 0.
- Result select:
  - MUL returns product[63:0]; MULH/MULHSU/MULHU return product[127:64].
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
  - Signed quotient is negative iff operand signs differ. Remainder takes the dividend's sign.
- Fast path, decided at the accept edge and going directly to DONE (done in the next cycle):
  - Divisor=0: DIV/DIVU -> 0xFFFF_FFFF_FFFF_FFFF; REM/REMU -> rs1_data.
  - Signed overflow: DIV with rs1=0x8000_0000_0000_0000 and rs2=all-ones -> 0x8000_0000_0000_0000; REM in the same case -> 0.
- DONE lasts exactly one cycle. Next edge -> IDLE, or -> accept (CALC or fast-path DONE) if start=1.
- Back-to-back: during the DONE cycle, done=1 with the old result. A start accepted at the end of that cycle replaces result/rd_out only when the new operation completes; result/rd_out update in the FIX/fast-path edge, never earlier.
- kill=1 at any edge: state -> IDLE, busy=0, done=0, result/rd_out unchanged. kill has priority over start.
- Arithmetic width: all operations use modulo-2^64 results; no exceptions or flags are raised.

Test Plan:
- MUL rs1=7, rs2=0xFFFF_FFFF_FFFF_FFFD (-3), rd_in=5 -> busy for 65 cycles; done one cycle; result=0xFFFF_FFFF_FFFF_FFEB; rd_out=5.
- MULHU rs1=rs2=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE. The same operands under MULH -> result=0.
- DIV rs1=0xFFFF_FFFF_FFFF_FFF9 (-7), rs2=2 -> result=0xFFFF_FFFF_FFFF_FFFD. The same operands under REM -> 0xFFFF_FFFF_FFFF_FFFF.
- Fast path:
  - DIVU rs1=0x1234, rs2=0 -> done the cycle after accept, result=all-ones, busy never high.
  - REMU with the same operands -> result=0x1234.
  - DIV 0x8000_0000_0000_0000 / all-ones -> 0x8000_0000_0000_0000.
- Pulse start again at cycle 10 of a CALC with different operands -> ignored; the original result is returned at cycle 65. A start during the DONE cycle begins a new operation whose done arrives 65 cycles later.
- kill asserted at cycle 30 of CALC -> busy drops the next cycle; no done; result keeps its prior value.
- reset asserted mid-CALC -> busy, done, result and rd_out all 0 immediately, without waiting for a clock edge.
